// File: rtl/ifmap_pop_sequencer.sv
// Sequences one tile of ifmap FIFO pops across the active PE rows, with a
// per-row diagonal skew (pointwise) or lockstep (depthwise), stalling the wavefront on empty FIFOs.
module ifmap_pop_sequencer #(
   parameter int unsigned NUM_ROWS = 32,
   parameter int unsigned LEN_W    = 6,
   parameter int unsigned STEP_W   = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          layer_type,
   input  logic [LEN_W-1:0]    row_num,
   input  logic [LEN_W-1:0]    pop_len,
   input  logic [NUM_ROWS-1:0] ifmap_fifo_empty,
   output logic [NUM_ROWS-1:0] ifmap_fifo_pop_en,
   output logic                busy,
   output logic                done
);

   localparam logic [1:0]  POINTWISE = 2'b00;
   localparam logic [1:0]  DEPTHWISE = 2'b01;
   localparam int unsigned MAX_LEN   = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_d;
   logic [STEP_W-1:0]   t, t_d;
   logic [LEN_W-1:0]    rows_q, rows_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                pw_q, pw_d;

   logic [NUM_ROWS-1:0] due;
   logic                stall;
   logic [STEP_W-1:0]   t_last;
   logic                supported;
   logic [LEN_W-1:0]    rows_clamp;
   logic [LEN_W-1:0]    len_clamp;

   assign supported  = (layer_type == POINTWISE) || (layer_type == DEPTHWISE);
   assign rows_clamp = (32'(row_num) > NUM_ROWS) ? LEN_W'(NUM_ROWS) : row_num;
   assign len_clamp  = (32'(pop_len) > MAX_LEN)  ? LEN_W'(MAX_LEN)  : pop_len;

   // Row r is due while t lies in its window [s_r, s_r + pop_len).
   always_comb begin
      logic [STEP_W-1:0] s;
      due = '0;
      s   = '0;
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
         s = pw_q ? STEP_W'(r) : '0;
         if ((STEP_W'(r) < STEP_W'(rows_q)) && (t >= s) && (t < s + STEP_W'(len_q)))
            due[r] = 1'b1;
      end
   end

   assign stall  = |(due & ifmap_fifo_empty);
   assign t_last = pw_q ? (STEP_W'(rows_q) + STEP_W'(len_q) - STEP_W'(2))
                        : (STEP_W'(len_q) - STEP_W'(1));

   // Next-state, step counter, config latch and pop strobes.
   always_comb begin
      state_d           = state;
      t_d               = t;
      rows_d            = rows_q;
      len_d             = len_q;
      pw_d              = pw_q;
      ifmap_fifo_pop_en = '0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               rows_d  = rows_clamp;
               len_d   = len_clamp;
               pw_d    = (layer_type == POINTWISE);
               t_d     = '0;
               state_d = (supported && (row_num != '0) && (pop_len != '0)) ? RUN : DONE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (!stall) begin
               ifmap_fifo_pop_en = due;
               if (t == t_last) state_d = DONE;
               else             t_d     = t + STEP_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            if (abort) t_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         t      <= '0;
         rows_q <= '0;
         len_q  <= '0;
         pw_q   <= 1'b0;
      end else begin
         state  <= state_d;
         t      <= t_d;
         rows_q <= rows_d;
         len_q  <= len_d;
         pw_q   <= pw_d;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
